// File: rtl/tlb_walk_ctrl_pkg.sv
// Shared constants, FSM encoding and PTE address helper for the TLB walk controller.
package tlb_walk_ctrl_pkg;

    localparam int VA_W              = 32;
    localparam int PA_W              = 20;
    localparam int PAGE_OFFSET_WIDTH = 12;
    localparam int PTE_VALID_BIT     = 31;
    localparam logic [31:0] PTBR     = 32'h0000_8000;

    // Zero padding that widens {vpn, 2'b00} to a 32-bit byte offset
    localparam int PTE_IDX_PAD = 32 - (VA_W - PAGE_OFFSET_WIDTH) - 2;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOOKUP = 3'd1,
        ST_CHECK  = 3'd2,
        ST_WALK   = 3'd3,
        ST_FILL   = 3'd4,
        ST_RESP   = 3'd5
    } state_e;

    function automatic logic [31:0] pte_addr(input logic [VA_W-1:0] va);
        logic [31:0] offset;
        offset = {{PTE_IDX_PAD{1'b0}}, va[VA_W-1:PAGE_OFFSET_WIDTH], 2'b00};
        return PTBR + offset;
    endfunction

endpackage

// File: rtl/tlb_walk_ctrl_if.sv
// Requester, TLB and page-table memory signals of the walk controller.
interface tlb_walk_ctrl_if;
    import tlb_walk_ctrl_pkg::*;

    logic [1:0]      req_valid;
    logic [VA_W-1:0] req_vaddr_i;
    logic [VA_W-1:0] req_vaddr_d;
    logic [1:0]      resp_valid;
    logic [PA_W-1:0] resp_paddr;
    logic            resp_fault;

    logic            tlb_read;
    logic            tlb_write;
    logic [VA_W-1:0] tlb_vaddr;
    logic [PA_W-1:0] tlb_paddr_new;
    logic [PA_W-1:0] tlb_paddr;
    logic            tlb_hit;

    logic            mem_req;
    logic [31:0]     mem_addr;
    logic            mem_ack;
    logic [31:0]     mem_rdata;

    // Environment side: requesters, TLB array and page-table memory
    modport master (
        output req_valid, req_vaddr_i, req_vaddr_d,
        input  resp_valid, resp_paddr, resp_fault,
        input  tlb_read, tlb_write, tlb_vaddr, tlb_paddr_new,
        output tlb_paddr, tlb_hit,
        input  mem_req, mem_addr,
        output mem_ack, mem_rdata
    );

    // Controller side
    modport slave (
        input  req_valid, req_vaddr_i, req_vaddr_d,
        output resp_valid, resp_paddr, resp_fault,
        output tlb_read, tlb_write, tlb_vaddr, tlb_paddr_new,
        input  tlb_paddr, tlb_hit,
        output mem_req, mem_addr,
        input  mem_ack, mem_rdata
    );

endinterface

// File: rtl/tlb_walk_ctrl_rr_arbiter.sv
// Two-way round-robin arbiter; a tie goes to the port that was not granted last.
module tlb_rr_arbiter (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       enable,
    output logic [1:0] grant
);

    logic last_grant_r;

    // One-hot grant selection
    always_comb begin
        grant = 2'b00;
        if (enable) begin
            case (req)
                2'b01:   grant = 2'b01;
                2'b10:   grant = 2'b10;
                2'b11:   grant = last_grant_r ? 2'b01 : 2'b10;
                default: grant = 2'b00;
            endcase
        end else begin
            grant = 2'b00;
        end
    end

    // Remember the most recently granted port
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_grant_r <= 1'b1;
        end else if (enable && (req != 2'b00)) begin
            last_grant_r <= grant[1];
        end else begin
            last_grant_r <= last_grant_r;
        end
    end

endmodule

// File: rtl/tlb_walk_ctrl.sv
// Shares one TLB between fetch and data ports; walks a one-level page table on a miss.
module tlb_walk_ctrl
    import tlb_walk_ctrl_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    tlb_walk_ctrl_if.slave  bus,
    output logic            busy,
    output logic [15:0]     miss_cnt
);

    state_e          state_r, state_n;
    logic [1:0]      grant_s;
    logic            port_r;
    logic [VA_W-1:0] vaddr_r;
    logic [PA_W-1:0] pte_r;
    logic [PA_W-1:0] paddr_r;
    logic            fault_r;
    logic            retried_r;
    logic [15:0]     miss_cnt_r;

    logic            ld_req_s, ld_pte_s, ld_resp_s, inc_miss_s, set_retry_s, clr_retry_s;
    logic [PA_W-1:0] paddr_n_s;
    logic            fault_n_s;
    logic            unused_pte_bits;

    // Reserved PTE bits between the valid flag and the translation are ignored
    assign unused_pte_bits = ^bus.mem_rdata[PTE_VALID_BIT-1:PA_W];

    tlb_rr_arbiter u_arb (
        .clk    (clk),
        .reset  (reset),
        .req    (bus.req_valid),
        .enable (state_r == ST_IDLE),
        .grant  (grant_s)
    );

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_n;
        end
    end

    // Next-state and datapath load strobes
    always_comb begin
        state_n     = state_r;
        ld_req_s    = 1'b0;
        ld_pte_s    = 1'b0;
        ld_resp_s   = 1'b0;
        inc_miss_s  = 1'b0;
        set_retry_s = 1'b0;
        clr_retry_s = 1'b0;
        paddr_n_s   = {PA_W{1'b0}};
        fault_n_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (grant_s != 2'b00) begin
                    state_n  = ST_LOOKUP;
                    ld_req_s = 1'b1;
                end else begin
                    state_n = ST_IDLE;
                end
            end
            ST_LOOKUP: state_n = ST_CHECK;
            ST_CHECK: begin
                if (bus.tlb_hit) begin
                    state_n   = ST_RESP;
                    ld_resp_s = 1'b1;
                    paddr_n_s = bus.tlb_paddr;
                end else if (!retried_r) begin
                    state_n    = ST_WALK;
                    inc_miss_s = 1'b1;
                end else begin
                    // The fill just written did not stick; give up rather than loop
                    state_n   = ST_RESP;
                    ld_resp_s = 1'b1;
                    fault_n_s = 1'b1;
                end
            end
            ST_WALK: begin
                if (bus.mem_ack && bus.mem_rdata[PTE_VALID_BIT]) begin
                    state_n  = ST_FILL;
                    ld_pte_s = 1'b1;
                end else if (bus.mem_ack) begin
                    state_n   = ST_RESP;
                    ld_resp_s = 1'b1;
                    fault_n_s = 1'b1;
                end else begin
                    state_n = ST_WALK;
                end
            end
            ST_FILL: begin
                state_n     = ST_LOOKUP;
                set_retry_s = 1'b1;
            end
            ST_RESP: begin
                state_n     = ST_IDLE;
                clr_retry_s = 1'b1;
            end
            default: state_n = ST_IDLE;
        endcase
    end

    // Request, PTE, response, retry and miss-counter registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            port_r     <= 1'b0;
            vaddr_r    <= {VA_W{1'b0}};
            pte_r      <= {PA_W{1'b0}};
            paddr_r    <= {PA_W{1'b0}};
            fault_r    <= 1'b0;
            retried_r  <= 1'b0;
            miss_cnt_r <= 16'd0;
        end else begin
            if (ld_req_s) begin
                port_r  <= grant_s[1];
                vaddr_r <= grant_s[1] ? bus.req_vaddr_d : bus.req_vaddr_i;
            end
            if (ld_pte_s) begin
                pte_r <= bus.mem_rdata[PA_W-1:0];
            end
            if (ld_resp_s) begin
                paddr_r <= paddr_n_s;
                fault_r <= fault_n_s;
            end
            if (set_retry_s) begin
                retried_r <= 1'b1;
            end else if (clr_retry_s) begin
                retried_r <= 1'b0;
            end else begin
                retried_r <= retried_r;
            end
            if (inc_miss_s) begin
                miss_cnt_r <= miss_cnt_r + 16'd1;
            end
        end
    end

    // Outputs decoded from state and registers only
    always_comb begin
        bus.resp_valid    = 2'b00;
        bus.mem_addr      = 32'd0;
        if (state_r == ST_RESP) begin
            bus.resp_valid = port_r ? 2'b10 : 2'b01;
        end else begin
            bus.resp_valid = 2'b00;
        end
        if (state_r == ST_WALK) begin
            bus.mem_addr = pte_addr(vaddr_r);
        end else begin
            bus.mem_addr = 32'd0;
        end
        bus.resp_paddr    = paddr_r;
        bus.resp_fault    = fault_r;
        bus.tlb_read      = (state_r == ST_LOOKUP);
        bus.tlb_write     = (state_r == ST_FILL);
        bus.tlb_vaddr     = vaddr_r;
        bus.tlb_paddr_new = pte_r;
        bus.mem_req       = (state_r == ST_WALK);
        busy              = (state_r != ST_IDLE);
        miss_cnt          = miss_cnt_r;
    end

endmodule
